// File: rtl/gobou_tiled_pkg.sv
// Shared widths, FSM encoding and output saturation for the tiled FC engine.
package gobou_tiled_pkg;

  localparam int unsigned CORE    = 8;
  localparam int unsigned CORELOG = $clog2(CORE);
  localparam int unsigned DWIDTH  = 16;
  localparam int unsigned FRACW   = 8;
  localparam int unsigned ACCW    = 40;
  localparam int unsigned IMGSIZE = 12;
  localparam int unsigned NETSIZE = 14;
  localparam int unsigned LWIDTH  = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_ACC,
    S_DRAIN,
    S_WRITE,
    S_NEXT,
    S_DONE
  } gobou_state_t;

  function automatic logic [DWIDTH-1:0] sat(input logic signed [ACCW-1:0] v);
    logic signed [ACCW-1:0] hi;
    logic signed [ACCW-1:0] lo;
    hi = {{(ACCW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    lo = {{(ACCW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
    if (v > hi) begin
      return {1'b0, {(DWIDTH-1){1'b1}}};
    end else if (v < lo) begin
      return {1'b1, {(DWIDTH-1){1'b0}}};
    end
    return v[DWIDTH-1:0];
  endfunction

endpackage

// File: rtl/gobou_tiled_lane.sv
// One MAC lane: private weight RAM, registered product, accumulator, bias load
// and ReLU/saturation on the result.
module gobou_tiled_lane
  import gobou_tiled_pkg::*;
(
  input  logic              clk,
  input  logic              xrst,
  input  logic              we,
  input  logic [NETSIZE-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              bias_v,
  input  logic              mac_v1,
  input  logic              mac_v2,
  input  logic              clr,
  input  logic              relu,
  input  logic [DWIDTH-1:0] x,
  output logic [DWIDTH-1:0] result
);

  logic [DWIDTH-1:0] mem [0:(1<<NETSIZE)-1];
  logic [DWIDTH-1:0] rdata_q;

  logic signed [2*DWIDTH-1:0] prod_q, prod_d;
  logic signed [ACCW-1:0]     acc_q, acc_d;
  logic        [2*DWIDTH-1:0] x_ext, w_ext;
  logic signed [ACCW-1:0]     prod_ext;
  logic signed [ACCW-1:0]     bias_ext;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  always_comb begin
    x_ext    = {{DWIDTH{x[DWIDTH-1]}}, x};
    w_ext    = {{DWIDTH{rdata_q[DWIDTH-1]}}, rdata_q};
    prod_ext = {{(ACCW-2*DWIDTH){prod_q[2*DWIDTH-1]}}, prod_q};
    bias_ext = {{(ACCW-DWIDTH){rdata_q[DWIDTH-1]}}, rdata_q};

    prod_d = prod_q;
    if (mac_v1) begin
      prod_d = x_ext * w_ext;
    end

    // Seeding the accumulator with the bias is equivalent to adding it after the sum.
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (bias_v) begin
      acc_d = bias_ext;
    end else if (mac_v2) begin
      acc_d = acc_q + (prod_ext >>> FRACW);
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  always_comb begin
    if (relu && acc_q[ACCW-1]) begin
      result = '0;
    end else begin
      result = sat(acc_q);
    end
  end

endmodule

// File: rtl/gobou_tiled.sv
// Tiled fully-connected layer engine: FSM, tile/input/write counters and the
// lane result write mux; MAC datapath lives in gobou_tiled_lane.
module gobou_tiled
  import gobou_tiled_pkg::*;
(
  input  logic               clk,
  input  logic               xrst,
  input  logic               req,
  input  logic               relu_en,
  input  logic [IMGSIZE-1:0] input_addr,
  input  logic [IMGSIZE-1:0] output_addr,
  input  logic [LWIDTH-1:0]  total_out,
  input  logic [LWIDTH-1:0]  total_in,
  input  logic [CORELOG:0]   net_we,
  input  logic [NETSIZE-1:0] net_addr,
  input  logic [DWIDTH-1:0]  write_net,
  input  logic [DWIDTH-1:0]  read_img,
  output logic               ack,
  output logic               mem_img_we,
  output logic [IMGSIZE-1:0] mem_img_addr,
  output logic [DWIDTH-1:0]  write_mem_img
);

  gobou_state_t state_q, state_d;

  logic               relu_q, relu_d;
  logic [IMGSIZE-1:0] in_addr_q, in_addr_d;
  logic [IMGSIZE-1:0] out_base_q, out_base_d;
  logic [LWIDTH-1:0]  tin_q, tin_d;
  logic [LWIDTH:0]    rem_q, rem_d;
  logic [NETSIZE-1:0] base_q, base_d;
  logic [LWIDTH-1:0]  j_q, j_d;
  logic               drain_q, drain_d;
  logic [CORELOG-1:0] widx_q, widx_d;
  logic               bias_v_q, bias_v_d;
  logic               mac1_q, mac1_d;
  logic               mac2_q, mac2_d;
  logic               clr;

  logic [NETSIZE-1:0] net_rd_addr;
  logic [DWIDTH-1:0]  lane_res [CORE];

  always_comb begin
    state_d    = state_q;
    relu_d     = relu_q;
    in_addr_d  = in_addr_q;
    out_base_d = out_base_q;
    tin_d      = tin_q;
    rem_d      = rem_q;
    base_d     = base_q;
    j_d        = j_q;
    drain_d    = drain_q;
    widx_d     = widx_q;
    clr        = 1'b0;

    bias_v_d = (state_q == S_BIAS);
    mac1_d   = (state_q == S_ACC);
    mac2_d   = mac1_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          relu_d     = relu_en;
          in_addr_d  = input_addr;
          out_base_d = output_addr;
          tin_d      = total_in;
          rem_d      = {1'b0, total_out};
          base_d     = '0;
          state_d    = (total_out == '0) ? S_DONE : S_BIAS;
        end
      end
      S_BIAS: begin
        j_d     = '0;
        drain_d = 1'b0;
        state_d = (tin_q == '0) ? S_DRAIN : S_ACC;
      end
      S_ACC: begin
        j_d = j_q + 1'b1;
        if (j_q == tin_q - 1'b1) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          widx_d  = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        widx_d = widx_q + 1'b1;
        // rem_q counts neurons left from this tile on, so it bounds the valid lanes.
        if ((widx_q == CORELOG'(CORE - 1)) ||
            ({1'b0, LWIDTH'(widx_q)} + 1'b1 >= rem_q)) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        clr = 1'b1;
        if (rem_q <= (LWIDTH+1)'(CORE)) begin
          state_d = S_DONE;
        end else begin
          rem_d      = rem_q - (LWIDTH+1)'(CORE);
          base_d     = base_q + NETSIZE'(tin_q) + 1'b1;
          out_base_d = out_base_q + IMGSIZE'(CORE);
          state_d    = S_BIAS;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q    <= S_IDLE;
      relu_q     <= 1'b0;
      in_addr_q  <= '0;
      out_base_q <= '0;
      tin_q      <= '0;
      rem_q      <= '0;
      base_q     <= '0;
      j_q        <= '0;
      drain_q    <= 1'b0;
      widx_q     <= '0;
      bias_v_q   <= 1'b0;
      mac1_q     <= 1'b0;
      mac2_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      relu_q     <= relu_d;
      in_addr_q  <= in_addr_d;
      out_base_q <= out_base_d;
      tin_q      <= tin_d;
      rem_q      <= rem_d;
      base_q     <= base_d;
      j_q        <= j_d;
      drain_q    <= drain_d;
      widx_q     <= widx_d;
      bias_v_q   <= bias_v_d;
      mac1_q     <= mac1_d;
      mac2_q     <= mac2_d;
    end
  end

  always_comb begin
    case (state_q)
      S_IDLE:  net_rd_addr = net_addr;
      S_BIAS:  net_rd_addr = base_q;
      default: net_rd_addr = base_q + NETSIZE'(j_q) + 1'b1;
    endcase
  end

  always_comb begin
    ack           = (state_q == S_IDLE);
    mem_img_we    = (state_q == S_WRITE);
    mem_img_addr  = '0;
    write_mem_img = '0;
    if (state_q == S_ACC) begin
      mem_img_addr = in_addr_q + IMGSIZE'(j_q);
    end else if (state_q == S_WRITE) begin
      mem_img_addr  = out_base_q + IMGSIZE'(widx_q);
      write_mem_img = lane_res[widx_q];
    end
  end

  for (genvar i = 0; i < CORE; i++) begin : g_lane
    gobou_tiled_lane u_lane (
      .clk    (clk),
      .xrst   (xrst),
      .we     ((state_q == S_IDLE) && (net_we == (CORELOG+1)'(i + 1))),
      .addr   (net_rd_addr),
      .wdata  (write_net),
      .bias_v (bias_v_q),
      .mac_v1 (mac1_q),
      .mac_v2 (mac2_q),
      .clr    (clr),
      .relu   (relu_q),
      .x      (read_img),
      .result (lane_res[i])
    );
  end

endmodule

// File: tb/tb_gobou_tiled.sv
// Scoreboard bench for gobou_tiled: a neuron-level fixed-point model predicts
// every image write; a forked monitor pops and compares each write it sees.
module tb_gobou_tiled;

  logic        clk = 1'b0;
  logic        xrst;
  logic        req;
  logic        relu_en;
  logic [11:0] input_addr;
  logic [11:0] output_addr;
  logic [9:0]  total_out;
  logic [9:0]  total_in;
  logic [3:0]  net_we;
  logic [13:0] net_addr;
  logic [15:0] write_net;
  logic [15:0] read_img;
  logic        ack;
  logic        mem_img_we;
  logic [11:0] mem_img_addr;
  logic [15:0] write_mem_img;

  always #5 clk = ~clk;

  gobou_tiled dut (
    .clk           (clk),
    .xrst          (xrst),
    .req           (req),
    .relu_en       (relu_en),
    .input_addr    (input_addr),
    .output_addr   (output_addr),
    .total_out     (total_out),
    .total_in      (total_in),
    .net_we        (net_we),
    .net_addr      (net_addr),
    .write_net     (write_net),
    .read_img      (read_img),
    .ack           (ack),
    .mem_img_we    (mem_img_we),
    .mem_img_addr  (mem_img_addr),
    .write_mem_img (write_mem_img)
  );

  logic [15:0] in_mem  [4096];
  logic [15:0] out_mem [4096];
  logic [15:0] exp_mem [4096];
  logic [15:0] w_ref [64][16];
  logic [15:0] b_ref [64];
  logic [15:0] x_ref [16];
  logic [27:0] expq [$];
  int n_vec = 0;
  int n_err = 0;

  // image memory read port, one cycle latency
  always @(posedge clk) read_img <= in_mem[mem_img_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_vec++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, req_v);
    end
  endtask

  task automatic monitor();
    logic [27:0] e;
    forever begin
      @(negedge clk);
      if (mem_img_we === 1'b1) begin
        if (expq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_write: actual addr %h data %h required no write",
                   mem_img_addr, write_mem_img);
        end else begin
          e = expq.pop_front();
          chk("wr_addr", {20'd0, mem_img_addr}, {20'd0, e[27:16]});
          chk("wr_data", {16'd0, write_mem_img}, {16'd0, e[15:0]});
        end
        out_mem[mem_img_addr] = write_mem_img;
      end
    end
  endtask

  function automatic logic [15:0] ref_neuron(int o, int tin, bit relu);
    longint acc;
    logic [15:0] r;
    acc = longint'($signed(b_ref[o]));
    for (int j = 0; j < tin; j++) begin
      acc += (longint'($signed(x_ref[j])) * longint'($signed(w_ref[o][j]))) >>> 8;
    end
    if (relu && acc < 0) acc = 0;
    if (acc > 32767) return 16'h7FFF;
    if (acc < -32768) return 16'h8000;
    r = acc[15:0];
    return r;
  endfunction

  task automatic wr_net(int lane, int addr, logic [15:0] d);
    @(negedge clk);
    net_we    = 4'(lane + 1);
    net_addr  = 14'(addr);
    write_net = d;
  endtask

  task automatic load_weights(int tout, int tin);
    for (int o = 0; o < tout; o++) begin
      int base;
      base = (o / 8) * (tin + 1);
      wr_net(o % 8, base, b_ref[o]);
      for (int j = 0; j < tin; j++) wr_net(o % 8, base + 1 + j, w_ref[o][j]);
    end
    @(negedge clk);
    net_we = '0;
  endtask

  task automatic fill_random(int tout, int tin);
    for (int o = 0; o < tout; o++) begin
      b_ref[o] = 16'($urandom);
      for (int j = 0; j < tin; j++) w_ref[o][j] = 16'($urandom);
    end
    for (int j = 0; j < tin; j++) x_ref[j] = 16'($urandom);
  endtask

  task automatic run_layer(bit relu, int ia, int oa, int tout, int tin, bit disturb);
    int cnt;
    int exp_cyc;
    int diffs;
    for (int j = 0; j < tin; j++) in_mem[(ia + j) % 4096] = x_ref[j];
    for (int o = 0; o < tout; o++) begin
      logic [15:0] r;
      int a;
      r = ref_neuron(o, tin, relu);
      a = (oa + o) % 4096;
      expq.push_back({12'(a), r});
      exp_mem[a] = r;
    end
    exp_cyc = (tout == 0) ? 1 : 1 + ((tout + 7) / 8) * (tin + 4) + tout;

    @(negedge clk);
    relu_en     = relu;
    input_addr  = 12'(ia);
    output_addr = 12'(oa);
    total_out   = 10'(tout);
    total_in    = 10'(tin);
    req         = 1'b1;
    @(negedge clk);
    req = 1'b0;
    cnt = 0;
    while (ack === 1'b0 && cnt < 5000) begin
      cnt++;
      if (disturb && cnt == 3) begin
        req       = 1'b1;
        total_out = 10'd3;
        net_we    = 4'd2;
        net_addr  = '0;
        write_net = 16'h7777;
      end else if (disturb && cnt == 4) begin
        req       = 1'b0;
        total_out = 10'(tout);
        net_we    = '0;
      end
      @(negedge clk);
    end
    req    = 1'b0;
    net_we = '0;
    chk("ack_low_cycles", 32'(cnt), 32'(exp_cyc));
    chk("queue_drained", 32'(expq.size()), 32'd0);
    diffs = 0;
    for (int a = 0; a < 4096; a++) if (out_mem[a] !== exp_mem[a]) diffs++;
    chk("mem_image", 32'(diffs), 32'd0);
  endtask

  initial begin
    xrst        = 1'b0;
    req         = 1'b0;
    relu_en     = 1'b0;
    input_addr  = '0;
    output_addr = '0;
    total_out   = '0;
    total_in    = '0;
    net_we      = '0;
    net_addr    = '0;
    write_net   = '0;
    for (int a = 0; a < 4096; a++) begin
      in_mem[a]  = '0;
      out_mem[a] = '0;
      exp_mem[a] = '0;
    end
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd1);
    chk("rst_we", {31'd0, mem_img_we}, 32'd0);
    chk("rst_addr", {20'd0, mem_img_addr}, 32'd0);
    chk("rst_data", {16'd0, write_mem_img}, 32'd0);
    xrst = 1'b1;
    repeat (2) @(negedge clk);

    // 4 inputs of 1.0 * 0.5 plus bias 0.25
    for (int o = 0; o < 8; o++) begin
      b_ref[o] = 16'h0040;
      for (int j = 0; j < 4; j++) w_ref[o][j] = 16'h0080;
    end
    for (int j = 0; j < 4; j++) x_ref[j] = 16'h0100;
    load_weights(8, 4);
    run_layer(1'b0, 100, 200, 8, 4, 1'b0);

    // two tiles, partial last tile
    fill_random(11, 5);
    load_weights(11, 5);
    run_layer(1'b0, 300, 500, 11, 5, 1'b0);

    // sum of -3.0 with and without ReLU
    b_ref[0] = '0;
    for (int j = 0; j < 3; j++) begin
      w_ref[0][j] = 16'hFF00;
      x_ref[j]    = 16'h0100;
    end
    load_weights(1, 3);
    run_layer(1'b1, 700, 600, 1, 3, 1'b0);
    run_layer(1'b0, 700, 601, 1, 3, 1'b0);

    // saturation both directions
    for (int j = 0; j < 8; j++) begin
      x_ref[j]    = 16'h7F00;
      w_ref[0][j] = 16'h7F00;
      w_ref[1][j] = 16'h8100;
    end
    b_ref[0] = '0;
    b_ref[1] = '0;
    load_weights(2, 8);
    run_layer(1'b0, 800, 900, 2, 8, 1'b0);

    // bias-only and empty layers
    fill_random(10, 0);
    load_weights(10, 0);
    run_layer(1'b0, 0, 1000, 10, 0, 1'b0);
    run_layer(1'b0, 0, 1100, 0, 4, 1'b0);

    // busy-time req/net_we are ignored, so a rerun without reload repeats results
    fill_random(11, 8);
    load_weights(11, 8);
    run_layer(1'b1, 1200, 1300, 11, 8, 1'b1);
    run_layer(1'b1, 1200, 1320, 11, 8, 1'b0);

    // reset in the middle of accumulation
    @(negedge clk);
    total_out   = 10'd11;
    total_in    = 10'd8;
    output_addr = 12'd1400;
    req         = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_abort", {31'd0, ack}, 32'd0);
    xrst = 1'b0;
    #1;
    chk("abort_ack", {31'd0, ack}, 32'd1);
    chk("abort_we", {31'd0, mem_img_we}, 32'd0);
    chk("abort_addr", {20'd0, mem_img_addr}, 32'd0);
    chk("abort_data", {16'd0, write_mem_img}, 32'd0);
    repeat (2) @(negedge clk);
    xrst = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_after_abort", {31'd0, ack}, 32'd1);
    load_weights(11, 8);
    run_layer(1'b0, 1200, 1500, 11, 8, 1'b0);

    // randomized layers, first one exercising address wrap
    for (int k = 0; k < 6; k++) begin
      int tout;
      int tin;
      int ia;
      int oa;
      bit rl;
      tout = $urandom_range(0, 24);
      tin  = $urandom_range(0, 16);
      ia   = (k == 0) ? 4090 : $urandom_range(0, 4095);
      oa   = (k == 0) ? 4085 : $urandom_range(1600, 4000);
      rl   = 1'($urandom);
      fill_random(tout, tin);
      load_weights(tout, tin);
      run_layer(rl, ia, oa, tout, tin, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
